// File: rtl/rgb_channel_sequencer.sv
// Sequences one RGB pixel at a time through a shared per-channel recovery unit
// and reassembles the three saturated results into an output pixel.
module rgb_channel_sequencer #(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 9,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_r,
  input  logic [DATA_W-1:0] s_g,
  input  logic [DATA_W-1:0] s_b,
  output logic [DATA_W-1:0] ch_a,
  output logic [DATA_W-1:0] ch_b,
  output logic [DATA_W-1:0] ch_c,
  output logic [1:0]        mux_sel,
  output logic              ch_valid,
  input  logic [RES_W-1:0]  res_in,
  input  logic              res_valid,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_r,
  output logic [DATA_W-1:0] m_g,
  output logic [DATA_W-1:0] m_b,
  output logic              sat_flag,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t            state, state_nx;
  logic [1:0]        icnt, rcnt;
  logic [TW-1:0]     tcnt;
  logic [DATA_W-1:0] slot_r, slot_g;
  logic              sat_acc;

  logic [DATA_W-1:0] res_sat;
  logic              res_ovf;
  logic              accept, capture, stray, third, timeout;

  always_comb begin
    res_ovf  = |res_in[RES_W-1:DATA_W];
    res_sat  = res_ovf ? '1 : res_in[DATA_W-1:0];
    s_ready  = (state == IDLE) && !rst;
    accept   = s_valid && s_ready;
    capture  = res_valid && ((state == ISSUE) || (state == WAIT)) && (rcnt != 2'd3);
    stray    = res_valid && !capture;
    third    = capture && (rcnt == 2'd2);
    timeout  = (state == WAIT) && !third && (tcnt == TW'(TIMEOUT - 1));
    mux_sel  = (state == ISSUE) ? icnt : 2'b11;
    ch_valid = (state == ISSUE);
    m_valid  = (state == OUT);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = ISSUE;
      // The third result may already be in hand by the last issue cycle.
      ISSUE: if (icnt == 2'd2) state_nx = (third || rcnt == 2'd3) ? OUT : WAIT;
      WAIT: begin
        if (third)        state_nx = OUT;
        else if (timeout) state_nx = IDLE;
      end
      OUT:   if (m_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ch_a     <= '0;
      ch_b     <= '0;
      ch_c     <= '0;
      icnt     <= '0;
      rcnt     <= '0;
      tcnt     <= '0;
      slot_r   <= '0;
      slot_g   <= '0;
      sat_acc  <= 1'b0;
      m_r      <= '0;
      m_g      <= '0;
      m_b      <= '0;
      sat_flag <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= stray || timeout;
      if (accept) begin
        ch_a    <= s_r;
        ch_b    <= s_g;
        ch_c    <= s_b;
        icnt    <= '0;
        rcnt    <= '0;
        tcnt    <= '0;
        slot_r  <= '0;
        slot_g  <= '0;
        sat_acc <= 1'b0;
      end
      if (state == ISSUE) icnt <= icnt + 2'd1;
      if (state == WAIT)  tcnt <= tcnt + 1'b1;
      if (capture) begin
        rcnt    <= rcnt + 2'd1;
        sat_acc <= sat_acc | res_ovf;
        case (rcnt)
          2'd0: slot_r <= res_sat;
          2'd1: slot_g <= res_sat;
          2'd2: begin
            // Output registers load on the same edge as the final result.
            m_r      <= slot_r;
            m_g      <= slot_g;
            m_b      <= res_sat;
            sat_flag <= sat_acc | res_ovf;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
